// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
//   Execute stage of the pipeline. Performs the ALU operation selected by
//   exe_cmd, owns the NZCV status register, resolves the branch target and
//   taken signal, and registers the results into the EX/MEM pipeline register
//   with freeze (hold) and flush (bubble) handling.
//
// Optional feature macro: EXE_STATUS_BYPASS_EN
//   Defined   : status presents the next-state NZCV combinationally while an
//               S-instruction is updating, so the condition check upstream
//               sees the new flags without a stall.
//   Undefined : status is the registered value only.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   freeze                hold every EX/MEM register and status
//   flush                 load a bubble into EX/MEM on the next edge
//   exe_cmd               ALU command
//   mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in   control bits from ID
//   val1, val2            ALU operands (Rn, shifted/immediate operand)
//   st_val_in             store data
//   dest_in               writeback register index
//   pc_in                 PC+4 of the instruction
//   imm24                 signed branch offset in words
//   br_taken, br_addr     combinational branch resolution
//   alu_res, st_val, dest, mem_r_en, mem_w_en, wb_en   EX/MEM register
//   status                NZCV, bit3=N .. bit0=V
// ---------------------------------------------------------------------------
module exe_stage #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          freeze,
    input  logic          flush,
    input  logic [3:0]    exe_cmd,
    input  logic          mem_r_en_in,
    input  logic          mem_w_en_in,
    input  logic          wb_en_in,
    input  logic          b_in,
    input  logic          s_in,
    input  logic [DW-1:0] val1,
    input  logic [DW-1:0] val2,
    input  logic [DW-1:0] st_val_in,
    input  logic [RW-1:0] dest_in,
    input  logic [DW-1:0] pc_in,
    input  logic [23:0]   imm24,
    output logic          br_taken,
    output logic [DW-1:0] br_addr,
    output logic [DW-1:0] alu_res,
    output logic [DW-1:0] st_val,
    output logic [RW-1:0] dest,
    output logic          mem_r_en,
    output logic          mem_w_en,
    output logic          wb_en,
    output logic [3:0]    status
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [DW-1:0] alu_res_q, alu_res_d;
    logic [DW-1:0] st_val_q,  st_val_d;
    logic [RW-1:0] dest_q,    dest_d;
    logic          mem_r_en_q, mem_r_en_d;
    logic          mem_w_en_q, mem_w_en_d;
    logic          wb_en_q,    wb_en_d;
    logic [3:0]    status_q,   status_d;

    logic [DW-1:0] alu_out;
    logic [3:0]    alu_nzcv;
    logic [DW:0]   add_sum;
    logic [DW:0]   sub_sum;
    logic [DW:0]   add_cin;
    logic [DW:0]   sub_cin;
    logic          c_flag;

    assign c_flag = status_q[1];

    // Subtraction is val1 + ~val2 + carry-in, so the carry out is directly
    // the no-borrow flag; SUB uses carry-in 1, SBC uses the current C.
    always_comb begin
        add_cin = '0;
        sub_cin = '0;
        add_cin[0] = (exe_cmd == CMD_ADC) ? c_flag : 1'b0;
        sub_cin[0] = (exe_cmd == CMD_SBC) ? c_flag : 1'b1;
        add_sum = {1'b0, val1} + {1'b0, val2} + add_cin;
        sub_sum = {1'b0, val1} + {1'b0, ~val2} + sub_cin;
    end

    always_comb begin
        alu_out  = '0;
        alu_nzcv = status_q;
        case (exe_cmd)
            CMD_MOV: alu_out = val2;
            CMD_MVN: alu_out = ~val2;
            CMD_AND: alu_out = val1 & val2;
            CMD_ORR: alu_out = val1 | val2;
            CMD_EOR: alu_out = val1 ^ val2;
            CMD_ADD, CMD_ADC: alu_out = add_sum[DW-1:0];
            CMD_SUB, CMD_SBC: alu_out = sub_sum[DW-1:0];
            default: alu_out = '0;
        endcase

        case (exe_cmd)
            CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
                alu_nzcv[3] = alu_out[DW-1];
                alu_nzcv[2] = (alu_out == '0);
            end
            CMD_ADD, CMD_ADC: begin
                alu_nzcv[3] = alu_out[DW-1];
                alu_nzcv[2] = (alu_out == '0);
                alu_nzcv[1] = add_sum[DW];
                alu_nzcv[0] = (val1[DW-1] == val2[DW-1]) &&
                              (alu_out[DW-1] != val1[DW-1]);
            end
            CMD_SUB, CMD_SBC: begin
                alu_nzcv[3] = alu_out[DW-1];
                alu_nzcv[2] = (alu_out == '0);
                alu_nzcv[1] = sub_sum[DW];
                alu_nzcv[0] = (val1[DW-1] != val2[DW-1]) &&
                              (alu_out[DW-1] != val1[DW-1]);
            end
            default: alu_nzcv = status_q;
        endcase
    end

    // Freeze has priority over flush; a flushed slot leaves status alone.
    always_comb begin
        alu_res_d  = alu_res_q;
        st_val_d   = st_val_q;
        dest_d     = dest_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        wb_en_d    = wb_en_q;
        status_d   = status_q;
        if (!freeze) begin
            if (flush) begin
                alu_res_d  = '0;
                st_val_d   = '0;
                dest_d     = '0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
                wb_en_d    = 1'b0;
            end else begin
                alu_res_d  = alu_out;
                st_val_d   = st_val_in;
                dest_d     = dest_in;
                mem_r_en_d = mem_r_en_in;
                mem_w_en_d = mem_w_en_in;
                wb_en_d    = wb_en_in;
                if (s_in) begin
                    status_d = alu_nzcv;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_q  <= '0;
            st_val_q   <= '0;
            dest_q     <= '0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            wb_en_q    <= 1'b0;
            status_q   <= 4'b0000;
        end else begin
            alu_res_q  <= alu_res_d;
            st_val_q   <= st_val_d;
            dest_q     <= dest_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            wb_en_q    <= wb_en_d;
            status_q   <= status_d;
        end
    end

    assign br_taken = b_in & ~freeze;
    assign br_addr  = pc_in + {{(DW-26){imm24[23]}}, imm24, 2'b00};

    assign alu_res  = alu_res_q;
    assign st_val   = st_val_q;
    assign dest     = dest_q;
    assign mem_r_en = mem_r_en_q;
    assign mem_w_en = mem_w_en_q;
    assign wb_en    = wb_en_q;

`ifdef EXE_STATUS_BYPASS_EN
    assign status = status_d;
`else
    assign status = status_q;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage
//   Directed bench for exe_stage: a table of ALU/flag vectors applied in
//   sequence (status carries over between rows), then hand-written sequences
//   for freeze, flush, freeze+flush, branch resolution and async reset.
// ---------------------------------------------------------------------------
module tb_exe_stage;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        flush;
    logic [3:0]  exe_cmd;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;
    logic [31:0] val1, val2, st_val_in, pc_in;
    logic [3:0]  dest_in;
    logic [23:0] imm24;
    logic        br_taken;
    logic [31:0] br_addr, alu_res, st_val;
    logic [3:0]  dest;
    logic        mem_r_en, mem_w_en, wb_en;
    logic [3:0]  status;

    int checks   = 0;
    int failures = 0;

    exe_stage #(.DW(32), .RW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freeze      (freeze),
        .flush       (flush),
        .exe_cmd     (exe_cmd),
        .mem_r_en_in (mem_r_en_in),
        .mem_w_en_in (mem_w_en_in),
        .wb_en_in    (wb_en_in),
        .b_in        (b_in),
        .s_in        (s_in),
        .val1        (val1),
        .val2        (val2),
        .st_val_in   (st_val_in),
        .dest_in     (dest_in),
        .pc_in       (pc_in),
        .imm24       (imm24),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .alu_res     (alu_res),
        .st_val      (st_val),
        .dest        (dest),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .wb_en       (wb_en),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [3:0]  cmd;
        logic        s;
        logic        mr;
        logic        mw;
        logic        wb;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] stv;
        logic [3:0]  dst;
        logic [31:0] e_res;
        logic [3:0]  e_status;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic s, input logic mr,
                         input logic mw, input logic wb, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] stv,
                         input logic [3:0] dst);
        exe_cmd     = cmd;
        s_in        = s;
        mem_r_en_in = mr;
        mem_w_en_in = mw;
        wb_en_in    = wb;
        val1        = v1;
        val2        = v2;
        st_val_in   = stv;
        dest_in     = dst;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, cmd, s, mr, mw, wb, v1, v2, stv, dst, exp res, exp status
        tbl[0]  = '{"add_ovf",   4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h1,        32'h11, 4'h1, 32'h80000000, 4'b1001};
        tbl[1]  = '{"sub_eq",    4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5,        32'h5,        32'h22, 4'h2, 32'h0,        4'b0110};
        tbl[2]  = '{"adc_c1",    4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1,        32'h1,        32'h33, 4'h3, 32'h3,        4'b0110};
        tbl[3]  = '{"load_addr", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100,      32'h8,        32'h44, 4'h4, 32'h108,      4'b0110};
        tbl[4]  = '{"sub_borrow",4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3,        32'h5,        32'h55, 4'h5, 32'hFFFFFFFE, 4'b1000};
        tbl[5]  = '{"sbc_c0_eq", 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3,        32'h3,        32'h66, 4'h6, 32'hFFFFFFFF, 4'b1000};
        tbl[6]  = '{"sbc_c0",    4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5,        32'h3,        32'h77, 4'h7, 32'h1,        4'b0010};
        tbl[7]  = '{"add_carry", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h1,        32'h88, 4'h8, 32'h0,        4'b0110};
        tbl[8]  = '{"mvn",       4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h99, 4'h9, 32'hFFFFFFFF, 4'b1010};
        tbl[9]  = '{"and",       4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 32'hF0F0,     32'h0FF0,     32'hAA, 4'hA, 32'h00F0,     4'b0010};
        tbl[10] = '{"orr_nos",   4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000,     32'h000F,     32'hBB, 4'hB, 32'hF00F,     4'b0010};
        tbl[11] = '{"eor_zero",  4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA,     32'hAAAA,     32'hCC, 4'hC, 32'h0,        4'b0110};
        tbl[12] = '{"nop0",      4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1,        32'h2,        32'hDD, 4'hD, 32'h0,        4'b0110};
        tbl[13] = '{"mov_neg",   4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h80000000, 32'hEE, 4'hE, 32'h80000000, 4'b1010};
        tbl[14] = '{"sub_vovf",  4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h1,        32'hFF, 4'hF, 32'h7FFFFFFF, 4'b0011};
        tbl[15] = '{"unused_f",  4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12,       32'h34,       32'h56, 4'h6, 32'h0,        4'b0011};

        rst_n  = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        b_in   = 1'b0;
        pc_in  = 32'h0;
        imm24  = 24'h0;
        drive(4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 4'h3);
        #12;
        chk("rst_alu_res", alu_res, 32'h0);
        chk("rst_st_val", st_val, 32'h0);
        chk("rst_dest", {28'h0, dest}, 32'h0);
        chk("rst_ctrl", {29'h0, mem_r_en, mem_w_en, wb_en}, 32'h0);
        chk("rst_status", {28'h0, status}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].cmd, tbl[i].s, tbl[i].mr, tbl[i].mw, tbl[i].wb,
                  tbl[i].v1, tbl[i].v2, tbl[i].stv, tbl[i].dst);
            step();
            chk({tbl[i].name, "_res"}, alu_res, tbl[i].e_res);
            chk({tbl[i].name, "_status"}, {28'h0, status}, {28'h0, tbl[i].e_status});
            chk({tbl[i].name, "_ctrl"}, {29'h0, mem_r_en, mem_w_en, wb_en},
                {29'h0, tbl[i].mr, tbl[i].mw, tbl[i].wb});
            chk({tbl[i].name, "_stv_dest"}, st_val ^ {28'h0, dest}, tbl[i].stv ^ {28'h0, tbl[i].dst});
            chk({tbl[i].name, "_br_taken"}, {31'h0, br_taken}, 32'h0);
        end

        // Store under freeze: previous row (unused_f) values must hold,
        // and s_in during freeze must not touch status.
        @(negedge clk);
        freeze = 1'b1;
        drive(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h4, 32'hDEAD, 4'hA);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("frz_res", alu_res, 32'h0);
            chk("frz_stv", st_val, 32'h56);
            chk("frz_dest", {28'h0, dest}, 32'h6);
            chk("frz_ctrl", {29'h0, mem_r_en, mem_w_en, wb_en}, 32'h2);
            chk("frz_status", {28'h0, status}, 32'h3);
        end
        @(negedge clk);
        freeze = 1'b0;
        s_in   = 1'b0;
        step();
        chk("st_res", alu_res, 32'h204);
        chk("st_stv", st_val, 32'hDEAD);
        chk("st_dest", {28'h0, dest}, 32'hA);
        chk("st_ctrl", {29'h0, mem_r_en, mem_w_en, wb_en}, 32'h2);
        chk("st_status", {28'h0, status}, 32'h3);

        // Branch resolution.
        @(negedge clk);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
        b_in  = 1'b1;
        pc_in = 32'h20;
        imm24 = 24'hFFFFFE;
        #1;
        chk("br_taken", {31'h0, br_taken}, 32'h1);
        chk("br_addr_neg", br_addr, 32'h18);
        pc_in = 32'hFFFFFFFC;
        imm24 = 24'h000001;
        #1;
        chk("br_addr_wrap", br_addr, 32'h0);
        pc_in = 32'h100;
        imm24 = 24'h800000;
        #1;
        chk("br_addr_min", br_addr, 32'hFE000100);
        freeze = 1'b1;
        #1;
        chk("br_taken_frz", {31'h0, br_taken}, 32'h0);
        freeze = 1'b0;

        // Flush: bubble regardless of incoming controls; status holds.
        @(negedge clk);
        b_in  = 1'b0;
        flush = 1'b1;
        drive(4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h1, 32'h77, 4'h9);
        step();
        chk("fl_ctrl", {29'h0, mem_r_en, mem_w_en, wb_en}, 32'h0);
        chk("fl_res", alu_res, 32'h0);
        chk("fl_dest", {28'h0, dest}, 32'h0);
        chk("fl_status", {28'h0, status}, 32'h3);

        // Load known values, then freeze+flush together must hold them.
        @(negedge clk);
        flush = 1'b0;
        drive(4'b0111, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h5, 32'h99, 4'h7);
        step();
        chk("pre_ff_res", alu_res, 32'h5);
        chk("pre_ff_status", {28'h0, status}, 32'h3);
        @(negedge clk);
        freeze = 1'b1;
        flush  = 1'b1;
        drive(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1, 32'h0, 4'h0);
        step();
        chk("ff_res", alu_res, 32'h5);
        chk("ff_ctrl", {29'h0, mem_r_en, mem_w_en, wb_en}, 32'h5);
        chk("ff_dest", {28'h0, dest}, 32'h7);
        chk("ff_status", {28'h0, status}, 32'h3);

        // Async reset mid-cycle, with freeze still asserted.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_res", alu_res, 32'h0);
        chk("arst_stv", st_val, 32'h0);
        chk("arst_dest", {28'h0, dest}, 32'h0);
        chk("arst_ctrl", {29'h0, mem_r_en, mem_w_en, wb_en}, 32'h0);
        chk("arst_status", {28'h0, status}, 32'h0);
        b_in   = 1'b1;
        freeze = 1'b0;
        #1;
        chk("arst_br_taken", {31'h0, br_taken}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
